// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the two-port data-memory arbiter.
//   state_e      : sequencer states IDLE -> ACCESS -> RESP
//   port_id_t    : requester identifier (port 0 = core LSU, port 1 = debug/DMA)
//   BE_*         : byte-enable patterns considered well-formed stores
//   be_is_legal  : helper that checks a byte-enable against the legal set
// Optional feature macro used by the arbiter: DMEM_ARB_ERR_EN
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef logic port_id_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE_0  = 4'b0001;
    localparam logic [3:0] BE_BYTE_1  = 4'b0010;
    localparam logic [3:0] BE_BYTE_2  = 4'b0100;
    localparam logic [3:0] BE_BYTE_3  = 4'b1000;

    // Only naturally aligned word, halfword and byte stores are well-formed.
    function automatic logic be_is_legal(input logic [3:0] be);
        logic legal;
        legal = 1'b0;
        if ((be == BE_WORD)    || (be == BE_HALF_LO) || (be == BE_HALF_HI) ||
            (be == BE_BYTE_0)  || (be == BE_BYTE_1)  || (be == BE_BYTE_2)  ||
            (be == BE_BYTE_3)) begin
            legal = 1'b1;
        end
        return legal;
    endfunction

endpackage

// File: rtl/dmem_be_merge.sv
// -----------------------------------------------------------------------------
// dmem_be_merge
// Combinational byte-lane merge used for read-modify-write stores.
//   old_i  : word currently held in memory
//   new_i  : store data, byte lanes aligned to the address
//   be_i   : one enable per byte lane, 1 = take the lane from new_i
//   word_o : merged word to be written back
// -----------------------------------------------------------------------------
module dmem_be_merge #(
    parameter int REG_SIZE = 32
) (
    input  logic [REG_SIZE-1:0]   old_i,
    input  logic [REG_SIZE-1:0]   new_i,
    input  logic [REG_SIZE/8-1:0] be_i,
    output logic [REG_SIZE-1:0]   word_o
);

    // Start from the old word and overwrite only the enabled lanes.
    always_comb begin
        word_o = old_i;
        for (int b = 0; b < REG_SIZE/8; b++) begin
            if (be_i[b]) begin
                word_o[8*b +: 8] = new_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory (combinational read, posedge write)
// between port 0 (core LSU) and port 1 (debug/DMA loader). Requests use a
// valid/ready handshake, grants are round-robin, stores are a single-cycle
// read-modify-write and every access returns a one-cycle registered response.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   req_valid_i/ready_o : per-port request handshake
//   req_we_i, req_be_i  : store flag and byte enables per port
//   req_addr_i          : byte address per port
//   req_wdata_i         : store data per port
//   rsp_valid_o         : response pulse to the owning port
//   rsp_rdata_o         : load data (0 for stores)
//   rsp_err_o           : access error flag
//   mem_we_o/addr_o/wdata_o/rdata_i : memory interface
// Optional feature: define DMEM_ARB_ERR_EN to flag out-of-range addresses and
// malformed byte enables; otherwise addresses wrap modulo memory size.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int REG_SIZE       = 32,
    parameter int MEM_SIZE_IN_KB = 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NUM_PORTS-1:0]                    req_valid_i,
    output logic [NUM_PORTS-1:0]                    req_ready_o,
    input  logic [NUM_PORTS-1:0]                    req_we_i,
    input  logic [NUM_PORTS-1:0][REG_SIZE/8-1:0]    req_be_i,
    input  logic [NUM_PORTS-1:0][REG_SIZE-1:0]      req_addr_i,
    input  logic [NUM_PORTS-1:0][REG_SIZE-1:0]      req_wdata_i,
    output logic [NUM_PORTS-1:0]                    rsp_valid_o,
    output logic [REG_SIZE-1:0]                     rsp_rdata_o,
    output logic                                    rsp_err_o,
    output logic                                    mem_we_o,
    output logic [REG_SIZE-1:0]                     mem_addr_o,
    output logic [REG_SIZE-1:0]                     mem_wdata_o,
    input  logic [REG_SIZE-1:0]                     mem_rdata_i
);

    localparam int NO_OF_REGS = MEM_SIZE_IN_KB * 1024 / 4;
    localparam int IDX_W      = $clog2(NO_OF_REGS);
    localparam int BE_W       = REG_SIZE / 8;

    state_e              state_q, state_d;
    port_id_t            last_grant_q, last_grant_d;
    port_id_t            grant_q, grant_d;
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [REG_SIZE-1:0] addr_q, addr_d;
    logic [REG_SIZE-1:0] wdata_q, wdata_d;
    logic [REG_SIZE-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;

    port_id_t            win;
    logic                access_err;
    logic [REG_SIZE-1:0] word_addr;
    logic [REG_SIZE-1:0] merged_word;
    logic                unused_addr_bits;

    // Round-robin pick: a lone requester always wins; on a tie the port that
    // was not granted last time goes first.
    always_comb begin
        win = 1'b0;
        if (&req_valid_i) begin
            win = ~last_grant_q;
        end else if (req_valid_i[1]) begin
            win = 1'b1;
        end
    end

`ifdef DMEM_ARB_ERR_EN
    assign access_err = (addr_q[REG_SIZE-1:2] >= (REG_SIZE-2)'(NO_OF_REGS)) ||
                        (we_q && !be_is_legal(be_q));
    assign word_addr  = {addr_q[REG_SIZE-1:2], 2'b00};
    assign unused_addr_bits = ^addr_q[1:0];
`else
    // Without checking, bits above the word index are dropped so the address
    // simply wraps around the memory.
    assign access_err = 1'b0;
    assign word_addr  = {{(REG_SIZE-IDX_W-2){1'b0}}, addr_q[IDX_W+1:2], 2'b00};
    assign unused_addr_bits = ^{addr_q[REG_SIZE-1:IDX_W+2], addr_q[1:0]};
`endif

    dmem_be_merge #(
        .REG_SIZE (REG_SIZE)
    ) u_merge (
        .old_i  (mem_rdata_i),
        .new_i  (wdata_q),
        .be_i   (be_q),
        .word_o (merged_word)
    );

    // State and captured-request registers; reset discards any transaction in
    // flight and leaves port 0 as the first winner.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Sequencer: IDLE accepts one request, ACCESS drives the memory for a
    // single cycle (store = read-modify-write), RESP pulses the response.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        req_ready_o  = '0;
        rsp_valid_o  = '0;
        rsp_rdata_o  = '0;
        rsp_err_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;

        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    req_ready_o[win] = 1'b1;
                    last_grant_d     = win;
                    grant_d          = win;
                    we_d             = req_we_i[win];
                    be_d             = req_be_i[win];
                    addr_d           = req_addr_i[win];
                    wdata_d          = req_wdata_i[win];
                    state_d          = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr_o = word_addr;
                err_d      = access_err;
                rdata_d    = '0;
                if (!access_err) begin
                    if (we_q) begin
                        mem_wdata_o = merged_word;
                        mem_we_o    = |be_q;
                    end else begin
                        rdata_d = mem_rdata_i;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_o[grant_q] = 1'b1;
                rsp_rdata_o          = rdata_q;
                rsp_err_o            = err_q;
                state_d              = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. Provides a behavioural data memory,
// a transaction-level reference model compared every cycle, and directed
// vectors with literal expectations. Honours DMEM_ARB_ERR_EN.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic             clk;
    logic             rstN;
    logic [1:0]       reqValid;
    logic [1:0]       reqReady;
    logic [1:0]       reqWe;
    logic [1:0][3:0]  reqBe;
    logic [1:0][31:0] reqAddr;
    logic [1:0][31:0] reqWdata;
    logic [1:0]       rspValid;
    logic [31:0]      rspRdata;
    logic             rspErr;
    logic             memWe;
    logic [31:0]      memAddr;
    logic [31:0]      memWdata;
    logic [31:0]      memRdata;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [31:0] envMem [256];
    logic [31:0] refMem [256];

    dmem_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .req_valid_i (reqValid),
        .req_ready_o (reqReady),
        .req_we_i    (reqWe),
        .req_be_i    (reqBe),
        .req_addr_i  (reqAddr),
        .req_wdata_i (reqWdata),
        .rsp_valid_o (rspValid),
        .rsp_rdata_o (rspRdata),
        .rsp_err_o   (rspErr),
        .mem_we_o    (memWe),
        .mem_addr_o  (memAddr),
        .mem_wdata_o (memWdata),
        .mem_rdata_i (memRdata)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory: combinational read, posedge write.
    assign memRdata = envMem[memAddr[9:2]];
    always @(posedge clk) begin
        if (memWe) envMem[memAddr[9:2]] <= memWdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Reference model: a request accepted in one cycle touches memory in the
    // next and is answered in the one after; nothing else may happen meanwhile.
    int          mBusyCycles = 0;
    logic        mLastGrant  = 1'b1;
    int          tPort;
    logic        tWe;
    logic [3:0]  tBe;
    logic [31:0] tAddr, tWdata, mRdata;
    logic        mErr;

    always @(negedge clk) begin
        logic [1:0]  eReady, eRspV;
        logic        eWe, eErr;
        logic [31:0] eAddr, eWdata, eRdata, mask, idx;
        eReady = '0; eRspV = '0; eWe = 1'b0; eErr = 1'b0;
        eAddr = '0; eWdata = '0; eRdata = '0;
        if (!rstN) begin
            mBusyCycles = 0;
            mLastGrant  = 1'b1;
        end else if (mBusyCycles == 0) begin
            if (reqValid != 2'b00) begin
                tPort = (reqValid == 2'b11) ? int'(!mLastGrant) : int'(reqValid[1]);
                eReady[tPort] = 1'b1;
                tWe = reqWe[tPort]; tBe = reqBe[tPort];
                tAddr = reqAddr[tPort]; tWdata = reqWdata[tPort];
                mLastGrant = tPort[0];
                mBusyCycles = 1;
            end
        end else if (mBusyCycles == 1) begin
            idx = tAddr >> 2;
`ifdef DMEM_ARB_ERR_EN
            eAddr = {tAddr[31:2], 2'b00};
            mErr = (idx >= 256) ||
                   (tWe && !(tBe inside {4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8}));
`else
            idx = idx % 256;
            eAddr = idx * 4;
            mErr = 1'b0;
`endif
            mRdata = '0;
            if (!mErr) begin
                if (tWe) begin
                    mask = '0;
                    for (int b = 0; b < 4; b++) if (tBe[b]) mask |= 32'hFF << (8 * b);
                    eWdata = (refMem[idx[7:0]] & ~mask) | (tWdata & mask);
                    eWe = (tBe != 4'b0000);
                    if (eWe) refMem[idx[7:0]] = eWdata;
                end else begin
                    mRdata = refMem[idx[7:0]];
                end
            end
            mBusyCycles = 2;
        end else begin
            eRspV[tPort] = 1'b1;
            eRdata = mRdata;
            eErr = mErr;
            mBusyCycles = 0;
        end
        checkOutput("model_ready",     {30'd0, reqReady}, {30'd0, eReady});
        checkOutput("model_mem_we",    {31'd0, memWe},    {31'd0, eWe});
        checkOutput("model_mem_addr",  memAddr,           eAddr);
        checkOutput("model_mem_wdata", memWdata,          eWdata);
        checkOutput("model_rsp_valid", {30'd0, rspValid}, {30'd0, eRspV});
        checkOutput("model_rsp_rdata", rspRdata,          eRdata);
        checkOutput("model_rsp_err",   {31'd0, rspErr},   {31'd0, eErr});
    end

    // Present one request on a port and wait (bounded) for its handshake.
    // Returns one time unit after the handshake edge, i.e. in the access cycle.
    task automatic applyStimulus(input int p, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int waited);
        logic accepted;
        accepted = 1'b0;
        waited = 0;
        reqWe[p] = we; reqBe[p] = be; reqAddr[p] = addr; reqWdata[p] = wdata;
        reqValid[p] = 1'b1;
        while (!accepted && waited < 20) begin
            @(negedge clk);
            if (reqReady[p]) accepted = 1'b1;
            else waited++;
            @(posedge clk); #1;
        end
        reqValid[p] = 1'b0;
        if (!accepted) begin
            compareCount++;
            mismatchCount++;
            $display("[TB] FAIL handshake_timeout: port %0d never ready after %0d cycles", p, waited);
        end
    endtask

    // Full transaction: returns what the memory side saw in the access cycle
    // and what the response side saw in the following cycle.
    task automatic runTxn(input int p, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic sWe, output logic [31:0] sWdata,
                          output logic [1:0] sRspV, output logic [31:0] sRdata,
                          output logic sErr, output int waited);
        applyStimulus(p, we, be, addr, wdata, waited);
        @(negedge clk);
        sWe = memWe; sWdata = memWdata;
        @(posedge clk); #1;
        @(negedge clk);
        sRspV = rspValid; sRdata = rspRdata; sErr = rspErr;
        @(posedge clk); #1;
    endtask

    task automatic resetDut();
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic        sWe, sErr;
        logic [31:0] sWdata, sRdata;
        logic [1:0]  sRspV, expReady;
        int          waited;

        for (int i = 0; i < 256; i++) begin
            envMem[i] = '0;
            refMem[i] = '0;
        end
        rstN = 1'b1;
        reqValid = '0; reqWe = '0; reqBe = '0; reqAddr = '0; reqWdata = '0;
        #2 rstN = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready",     {30'd0, reqReady}, 32'd0);
        checkOutput("reset_rsp_valid", {30'd0, rspValid}, 32'd0);
        checkOutput("reset_mem_we",    {31'd0, memWe},    32'd0);
        @(posedge clk); #1 rstN = 1'b1;

        $display("[TB] word store then load from the other port");
        runTxn(0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, sWe, sWdata, sRspV, sRdata, sErr, waited);
        checkOutput("st_mem_we",    {31'd0, sWe},   32'd1);
        checkOutput("st_mem_wdata", sWdata,         32'hDEADBEEF);
        checkOutput("st_rsp_valid", {30'd0, sRspV}, 32'd1);
        runTxn(1, 1'b0, 4'b0000, 32'h10, 32'h0, sWe, sWdata, sRspV, sRdata, sErr, waited);
        checkOutput("ld_rsp_valid", {30'd0, sRspV}, 32'd2);
        checkOutput("ld_rdata",     sRdata,         32'hDEADBEEF);

        $display("[TB] byte store merges into existing word");
        runTxn(0, 1'b1, 4'b0100, 32'h10, 32'h00AA0000, sWe, sWdata, sRspV, sRdata, sErr, waited);
        checkOutput("byte_mem_wdata", sWdata, 32'hDEAABEEF);
        runTxn(1, 1'b0, 4'b0000, 32'h10, 32'h0, sWe, sWdata, sRspV, sRdata, sErr, waited);
        checkOutput("byte_reload", sRdata, 32'hDEAABEEF);

        $display("[TB] empty byte-enable store");
        runTxn(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, sWe, sWdata, sRspV, sRdata, sErr, waited);
        checkOutput("be0_mem_we",    {31'd0, sWe},   32'd0);
        checkOutput("be0_rsp_valid", {30'd0, sRspV}, 32'd1);
        runTxn(1, 1'b0, 4'b0000, 32'h10, 32'h0, sWe, sWdata, sRspV, sRdata, sErr, waited);
        checkOutput("be0_reload", sRdata, 32'hDEAABEEF);

        $display("[TB] both ports requesting continuously");
        resetDut();
        reqWe = 2'b00;
        reqAddr[0] = 32'h10; reqAddr[1] = 32'h20;
        reqValid = 2'b11;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            expReady = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
            checkOutput($sformatf("rr_ready_c%0d", c), {30'd0, reqReady}, {30'd0, expReady});
            @(posedge clk); #1;
        end
        reqValid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] reset during a store access");
        runTxn(0, 1'b1, 4'b1111, 32'h20, 32'h11112222, sWe, sWdata, sRspV, sRdata, sErr, waited);
        applyStimulus(0, 1'b1, 4'b1111, 32'h20, 32'h12345678, waited);
        checkOutput("pre_rst_mem_we", {31'd0, memWe}, 32'd1);
        rstN = 1'b0;
        #1 checkOutput("rst_mem_we_drop", {31'd0, memWe}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_no_rsp", {30'd0, rspValid}, 32'd0);
        end
        @(posedge clk); #1 rstN = 1'b1;
        runTxn(1, 1'b0, 4'b0000, 32'h20, 32'h0, sWe, sWdata, sRspV, sRdata, sErr, waited);
        checkOutput("post_rst_wait",  waited,         32'd0);
        checkOutput("post_rst_rdata", sRdata,         32'h11112222);
        checkOutput("post_rst_rspv",  {30'd0, sRspV}, 32'd2);

        $display("[TB] out-of-range address and malformed byte enables");
        runTxn(0, 1'b1, 4'b1111, 32'h0, 32'hCAFEF00D, sWe, sWdata, sRspV, sRdata, sErr, waited);
        runTxn(1, 1'b0, 4'b0000, 32'h400, 32'h0, sWe, sWdata, sRspV, sRdata, sErr, waited);
`ifdef DMEM_ARB_ERR_EN
        checkOutput("oor_err",   {31'd0, sErr}, 32'd1);
        checkOutput("oor_rdata", sRdata,        32'd0);
`else
        checkOutput("oor_err",   {31'd0, sErr}, 32'd0);
        checkOutput("oor_rdata", sRdata,        32'hCAFEF00D);
`endif
        runTxn(0, 1'b1, 4'b0101, 32'h0, 32'hFFFFFFFF, sWe, sWdata, sRspV, sRdata, sErr, waited);
        runTxn(1, 1'b0, 4'b0000, 32'h0, 32'h0, sWe, sWdata, sRspV, sRdata, sErr, waited);
`ifdef DMEM_ARB_ERR_EN
        checkOutput("badbe_reload", sRdata, 32'hCAFEF00D);
`else
        checkOutput("badbe_reload", sRdata, 32'hCAFFF0FF);
`endif

        checkOutput("final_word_0x10", envMem[4], 32'hDEAABEEF);
        checkOutput("final_word_0x20", envMem[8], 32'h11112222);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
